fht_control_param: RTL



---
 rtl/fht_control_param_if.sv | 47 ++++
 rtl/fht_control_param.sv | 119 +++++++++++
 2 files changed

// File: rtl/fht_control_param_if.sv
// fht_control_param_if: start/done handshake and address/strobe bus of the FHT sequencer
//   start, abort               host -> sequencer control
//   rdy, done                  idle flag and one-cycle completion pulse
//   stage, st_zero, st_last    current stage and first/last-stage flags
//   sector, second_part_subsec sector index and upper-half-of-sector flag
//   addr_rd_0..3               direct (0,2) and mirrored (1,3) read addresses
//   addr_wr, addr_wr_bias      read addresses delayed by the pipeline latency
//   addr_coef                  twiddle ROM address
//   we_a, we_b                 bank-set write strobes
//   source_data, source_cont   read bank select and host bank ownership
interface fht_control_param_if #(
  parameter int A_BIT = 8,
  parameter int ST_BIT = 4
);
  logic start;
  logic abort;
  logic rdy;
  logic done;
  logic [ST_BIT-1:0] stage;
  logic st_zero;
  logic st_last;
  logic [A_BIT:0] sector;
  logic second_part_subsec;
  logic [A_BIT-1:0] addr_rd_0;
  logic [A_BIT-1:0] addr_rd_1;
  logic [A_BIT-1:0] addr_rd_2;
  logic [A_BIT-1:0] addr_rd_3;
  logic [A_BIT-1:0] addr_wr;
  logic [A_BIT-1:0] addr_wr_bias;
  logic [A_BIT-1:0] addr_coef;
  logic we_a;
  logic we_b;
  logic source_data;
  logic source_cont;
  modport master (
    output start, abort,
    input rdy, done, stage, st_zero, st_last, sector, second_part_subsec,
    input addr_rd_0, addr_rd_1, addr_rd_2, addr_rd_3, addr_wr, addr_wr_bias, addr_coef,
    input we_a, we_b, source_data, source_cont
  );
  modport slave (
    input start, abort,
    output rdy, done, stage, st_zero, st_last, sector, second_part_subsec,
    output addr_rd_0, addr_rd_1, addr_rd_2, addr_rd_3, addr_wr, addr_wr_bias, addr_coef,
    output we_a, we_b, source_data, source_cont
  );
endinterface

// File: rtl/fht_control_param.sv
// fht_control_param: parametrised stage/address sequencer for the 4-bank radix-2 FHT core
//   iCLK    clock
//   iRESET  asynchronous active-low reset
//   bus     slave side of fht_control_param_if: start/abort in; ready/done, stage flags,
//           read/write/coefficient addresses, bank write strobes and bank selects out
module fht_control_param #(
  parameter int A_BIT = 8,
  parameter int LAT = 6,
  parameter int ST_BIT = 4
) (
  input logic iCLK,
  input logic iRESET,
  fht_control_param_if.slave bus
);
  localparam int S = A_BIT + 2;
  localparam int RD_LEN = 2 ** (A_BIT + 1);
  localparam int T_END = RD_LEN + LAT - 1;
  localparam int T_BIT = $clog2(T_END + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  localparam logic LAT_ODD = 1'(LAT % 2);
  logic [0:0] state;
  logic [ST_BIT-1:0] s;
  logic [ST_BIT-1:0] k;
  logic [ST_BIT-1:0] sh;
  logic [T_BIT-1:0] t;
  logic busy;
  logic rd_ph;
  logic last;
  logic t_end;
  logic strobe;
  logic src_cont;
  logic [A_BIT-1:0] r;
  logic [A_BIT-1:0] mask;
  logic [A_BIT-1:0] off;
  logic [A_BIT-1:0] base;
  logic [A_BIT-1:0] mir;
  logic [A_BIT-1:0] coef;
  logic [A_BIT:0] div;
  logic [A_BIT:0] sector;
  logic half;
  logic [LAT-1:0][A_BIT-1:0] dl_d;
  logic [LAT-1:0][A_BIT-1:0] dl_m;
  // Sector size is 2^(A_BIT-k): stage 0 and stage 1 share the full half-frame sector,
  // every later stage halves it, so the whole address split reduces to a mask and a shift.
  always_comb begin
    busy = state == RUN;
    last = s == ST_BIT'(S - 1);
    t_end = t == T_BIT'(T_END);
    rd_ph = busy && (t < T_BIT'(RD_LEN));
    r = rd_ph ? t[A_BIT:1] : '0;
    k = (s == '0) ? '0 : s - 1'b1;
    sh = ST_BIT'(A_BIT) - k;
    mask = {A_BIT{1'b1}} >> k;
    div = {1'b0, mask} + 1'b1;
    off = r & mask;
    base = r & ~mask;
    mir = (s == '0) ? r : (base | (-off & mask));
    coef = (s == '0) ? '0 : off << k;
    sector = {1'b0, r} >> sh;
    half = rd_ph && ({1'b0, off} >= (div >> 1));
    strobe = busy && (t >= T_BIT'(LAT)) && (t[0] != LAT_ODD);
  end
  always_ff @(posedge iCLK or negedge iRESET)
    if (!iRESET) begin
      state <= IDLE;
      s <= '0;
      t <= '0;
      src_cont <= 1'b1;
      dl_d <= '0;
      dl_m <= '0;
    end else begin
      src_cont <= ~busy;
      if (!busy) begin
        state <= bus.start ? RUN : IDLE;
        s <= '0;
        t <= '0;
      end else if (bus.abort) begin
        state <= IDLE;
        s <= '0;
        t <= '0;
      end else if (t_end) begin
        state <= last ? IDLE : RUN;
        s <= last ? '0 : s + 1'b1;
        t <= '0;
      end else
        t <= t + 1'b1;
      // An abort flushes in-flight write addresses so a restart never sees stale ones.
      if (busy && bus.abort) begin
        dl_d <= '0;
        dl_m <= '0;
      end else begin
        for (int i = LAT - 1; i > 0; i--) begin
          dl_d[i] <= dl_d[i-1];
          dl_m[i] <= dl_m[i-1];
        end
        dl_d[0] <= r;
        dl_m[0] <= mir;
      end
    end
  assign bus.rdy = ~busy;
  assign bus.done = busy && t_end && last;
  assign bus.stage = s;
  assign bus.st_zero = busy && (s == '0);
  assign bus.st_last = busy && last;
  assign bus.sector = sector;
  assign bus.second_part_subsec = half;
  assign bus.addr_rd_0 = r;
  assign bus.addr_rd_2 = r;
  assign bus.addr_rd_1 = mir;
  assign bus.addr_rd_3 = mir;
  assign bus.addr_wr = dl_d[LAT-1];
  assign bus.addr_wr_bias = dl_m[LAT-1];
  assign bus.addr_coef = coef;
  assign bus.we_a = strobe && s[0];
  assign bus.we_b = strobe && !s[0];
  assign bus.source_data = busy && s[0];
  assign bus.source_cont = src_cont;
endmodule
